tick_slot_arbiter: RTL and testbench
====================================

Name: tick_slot_arbiter

Overview:
- Shares one downstream resource among N_REQ requesters in time slots paced by the periodic sync tick (1-cycle pulse every 4 clk from the sync generator).
- Round-robin arbitration happens only on tick cycles. A grant lasts a programmable number of ticks, or ends earlier when the owner drops its request.
- Sits between the sync generator and the shared datapath. It is the sequencer deciding who drives the resource each slot.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= N_REQ
- LEN_W, 3, width of slot_len config input

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- tick  input  1  slot-pacing pulse (1 cycle high), from the sync generator
- req  input  N_REQ  per-requester request level; held high while service is wanted
- slot_len  input  LEN_W  grant length in ticks; 0 treated as 1
- grant  output  N_REQ  one-hot grant, registered; all-zero when idle
- grant_id  output  ID_W  index of current owner; holds last owner when idle
- busy  output  1  high while a grant is active (equals |grant)
- grant_start  output  1  1-cycle pulse in the first cycle grant is high
- grant_end  output  1  1-cycle pulse in the first cycle grant is low after a grant

Behaviour:
- Reset (async, rst=1), all of the following:
  - grant=0, grant_id=0, busy=0, grant_start=0, grant_end=0.
  - FSM=IDLE, tick counter=0.
  - RR pointer=N_REQ-1, so requester 0 has first priority after reset.
- FSM states: IDLE, GRANT.
- IDLE, arbitration:
  - When tick=1 and |req=1, select the first requester with req=1, searching from pointer+1 upward with wrap modulo N_REQ.
  - On the next edge:
    - grant[sel]=1, grant_id=sel, pointer=sel.
    - Latched length L = (slot_len==0 ? 1 : slot_len).
    - Tick counter=0, state->GRANT.
  - Latency: grant visible the cycle after the arbitrating tick. grant_start is high in that same cycle.
  - tick=0, or tick=1 with req=0: stay IDLE, no outputs change.
- GRANT:
  - Each tick increments the tick counter. The arbitrating tick is not counted.
  - End condition A: tick=1 and counter==L-1 (the L-th tick after grant start).
  - End condition B: req[grant_id]=0 (early release); no tick needed.
  - On either end condition: on the next edge grant=0, busy=0, state->IDLE, and grant_end pulses in that cycle.
  - A and B in the same cycle: a single end and a single grant_end pulse.
- Back-to-back: the ending tick is consumed by GRANT, so IDLE cannot re-arbitrate on it. The next grant comes on the following tick, giving a gap of one tick period (4 clk at the nominal rate). This is intentional; it gives the resource a turnaround slot.
- slot_len changes during GRANT have no effect; it is sampled only at arbitration.
- req of non-owners is ignored during GRANT. A request must stay high until the next arbitrating tick to be considered; no request memory.
- Counter width is LEN_W and must not overflow: counter max = L-1 <= 2**LEN_W-2.
- grant is always one-hot or zero; never more than one bit.
- rst asserted mid-grant: outputs drop to 0 asynchronously and no grant_end pulse is produced. After release, requester 0 has priority again.
- tick high for more than 1 cycle is out of spec; each high cycle counts as one tick.

Test Plan:
- Reset/first grant: rst pulse, then req=4'b1010, slot_len=2, tick every 4 clk.
  - Required: grant=4'b0010 and grant_id=1 the cycle after the first tick; grant_start pulse.
  - grant ends the cycle after the 2nd following tick; grant_end pulse.
- Round-robin rotation: req=4'b1111 held, slot_len=1.
  - Required: grant_id sequence 0,1,2,3,0, each grant 4 clk long, separated by 4-clk idle gaps.
- Early release: owner 2 granted with slot_len=5; drop req[2] 3 clk after grant_start.
  - Required: grant=0 and grant_end high exactly 1 clk later; next grant not before the next tick.
- slot_len=0 and mid-grant change: slot_len=0 gives 1-tick grants. Set slot_len=3 at grant start, change to 7 during the grant.
  - Required: grant lasts exactly 3 ticks.
- Simultaneous end: req[owner] drops in the same cycle as the L-th tick.
  - Required: exactly one grant_end pulse; state IDLE.
- Reset mid-grant: assert rst while grant=4'b0100.
  - Required: grant=0 immediately (asynchronous), no grant_end.
  - After release with req=4'b1111: first grant_id=0.

Source files
------------

// File: rtl/tick_slot_arbiter_if.sv
// Bundle between the sync-paced slot arbiter and its environment: tick, requests,
// slot length in; one-hot grant with owner index and start/end pulses out.
interface tick_slot_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int LEN_W = 3
);
   logic             tick;
   logic [N_REQ-1:0] req;
   logic [LEN_W-1:0] slot_len;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_id;
   logic             busy;
   logic             grant_start;
   logic             grant_end;

   modport master (
      output tick, req, slot_len,
      input  grant, grant_id, busy, grant_start, grant_end
   );

   modport slave (
      input  tick, req, slot_len,
      output grant, grant_id, busy, grant_start, grant_end
   );
endinterface

// File: rtl/tick_slot_arbiter.sv
// Round-robin owner of a shared resource, re-arbitrated only on sync ticks; a grant
// lasts slot_len ticks (0 means 1) or ends early when the owner drops its request.
module tick_slot_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int LEN_W = 3
) (
   input logic clk,
   input logic rst,
   tick_slot_arbiter_if.slave bus
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [ID_W-1:0]  grantId_q, grantId_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             grantStart_q, grantStart_d;
   logic             grantEnd_q, grantEnd_d;

   logic [ID_W-1:0]  sel;
   logic             found;
   logic [ID_W-1:0]  candidate;
   logic [LEN_W-1:0] lenEff;
   logic             endByTicks;
   logic             endByRelease;

   // Search starts just past the last owner so every requester gets a turn.
   always_comb begin
      found     = 1'b0;
      sel       = ptr_q;
      candidate = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         candidate = ID_W'((int'(ptr_q) + k) % N_REQ);
         if (!found && bus.req[candidate]) begin
            found = 1'b1;
            sel   = candidate;
         end
      end
   end

   assign lenEff       = (bus.slot_len == '0) ? LEN_W'(1) : bus.slot_len;
   assign endByTicks   = bus.tick && (cnt_q == len_q - LEN_W'(1));
   assign endByRelease = !bus.req[grantId_q];

   // Next-state logic: arbitrate on a tick while idle; count ticks and watch for
   // release while granted. The tick that ends a grant is never reused to arbitrate.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      grantId_d    = grantId_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      grantStart_d = 1'b0;
      grantEnd_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.tick && found) begin
               state_d      = GRANT;
               grant_d      = N_REQ'(1) << sel;
               grantId_d    = sel;
               ptr_d        = sel;
               len_d        = lenEff;
               cnt_d        = '0;
               grantStart_d = 1'b1;
            end
         end
         GRANT: begin
            if (endByTicks || endByRelease) begin
               state_d    = IDLE;
               grant_d    = '0;
               grantEnd_d = 1'b1;
            end else if (bus.tick) begin
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Reset leaves requester 0 first in line by parking the pointer on the last index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         grantId_q    <= '0;
         ptr_q        <= ID_W'(N_REQ - 1);
         cnt_q        <= '0;
         len_q        <= LEN_W'(1);
         grantStart_q <= 1'b0;
         grantEnd_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         grantId_q    <= grantId_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         grantStart_q <= grantStart_d;
         grantEnd_q   <= grantEnd_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_id    = grantId_q;
   assign bus.busy        = |grant_q;
   assign bus.grant_start = grantStart_q;
   assign bus.grant_end   = grantEnd_q;

endmodule

// File: tb/tb_tick_slot_arbiter.sv
// Bench for tick_slot_arbiter: directed slot scenarios with literal expectations,
// then random requests, all compared every cycle against a ticks-remaining model.
module tb_tick_slot_arbiter;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int LEN_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   assertCount = 0;
   int   failCount   = 0;
   int   tickPhase   = 0;

   tick_slot_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

   tick_slot_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Model state: who owns the slot, how many ticks it has left, and whose turn is next.
   typedef struct {
      int owner;
      int last;
      int ptr;
      int left;
      bit st;
      bit en;
   } model_t;

   model_t m = '{owner: -1, last: 0, ptr: N_REQ - 1, left: 0, st: 1'b0, en: 1'b0};

   function automatic model_t resetModel();
      model_t r;
      r = '{owner: -1, last: 0, ptr: N_REQ - 1, left: 0, st: 1'b0, en: 1'b0};
      return r;
   endfunction

   function automatic model_t modelStep(model_t cur, logic tk, logic [N_REQ-1:0] rq,
                                        logic [LEN_W-1:0] sl);
      model_t nx;
      int     c;
      nx    = cur;
      nx.st = 1'b0;
      nx.en = 1'b0;
      if (cur.owner >= 0) begin
         if (!rq[cur.owner] || (tk && cur.left == 1)) begin
            nx.owner = -1;
            nx.en    = 1'b1;
         end else if (tk) begin
            nx.left = cur.left - 1;
         end
      end else if (tk && rq != '0) begin
         for (int k = 1; k <= N_REQ; k++) begin
            c = (cur.ptr + k) % N_REQ;
            if (rq[c] && nx.owner < 0) nx.owner = c;
         end
         nx.ptr  = nx.owner;
         nx.last = nx.owner;
         nx.left = (sl == 0) ? 1 : int'(sl);
         nx.st   = 1'b1;
      end
      return nx;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= resetModel();
      else     m <= modelStep(m, bus.tick, bus.req, bus.slot_len);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle the registered outputs must match what the model says.
   always @(negedge clk) begin
      logic [N_REQ-1:0] expGrant;
      expGrant = (m.owner >= 0) ? (N_REQ'(1) << m.owner) : '0;
      checkOutput("grant", 32'(bus.grant), 32'(expGrant));
      checkOutput("grant_id", 32'(bus.grant_id), 32'(m.last));
      checkOutput("busy", 32'(bus.busy), 32'(m.owner >= 0));
      checkOutput("grant_start", 32'(bus.grant_start), 32'(m.st));
      checkOutput("grant_end", 32'(bus.grant_end), 32'(m.en));
   end

   task automatic applyStimulus(input logic [N_REQ-1:0] rq, input logic [LEN_W-1:0] sl);
      bus.req      = rq;
      bus.slot_len = sl;
   endtask

   // One clock: land on the falling edge and drive the nominal every-4-clk tick.
   task automatic tickCycle();
      @(negedge clk);
      bus.tick  = (tickPhase == 3);
      tickPhase = (tickPhase + 1) % 4;
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst      = 1'b1;
      bus.tick = 1'b0;
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      tickPhase = 0;
   endtask

   task automatic waitStart(output int waited);
      waited = 0;
      do begin
         tickCycle();
         waited++;
      end while (!bus.grant_start && waited < 60);
      if (!bus.grant_start) checkOutput("waitStart timeout", 32'd0, 32'd1);
   endtask

   task automatic measureBusy(input int startCount, output int n);
      n = startCount;
      for (int i = 0; i < 100; i++) begin
         tickCycle();
         if (!bus.busy) break;
         n++;
      end
      if (bus.busy) checkOutput("measureBusy timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int waited;
      int n;
      bus.tick     = 1'b0;
      bus.req      = '0;
      bus.slot_len = '0;
      #1 rst = 1'b1;
      #20;

      // First grant after reset, req=1010, slot_len=2
      applyStimulus(4'b1010, 3'd2);
      applyReset();
      waitStart(waited);
      checkOutput("first grant", 32'(bus.grant), 32'h2);
      checkOutput("first grant_id", 32'(bus.grant_id), 32'd1);
      checkOutput("first start latency", 32'(waited), 32'd5);
      measureBusy(1, n);
      checkOutput("first grant length", 32'(n), 32'd8);
      checkOutput("first grant_end", 32'(bus.grant_end), 32'd1);

      // Round-robin rotation with one-tick slots
      applyStimulus(4'b1111, 3'd1);
      applyReset();
      waitStart(waited);
      for (int g = 0; g < 5; g++) begin
         checkOutput("rr grant_id", 32'(bus.grant_id), 32'(g % 4));
         measureBusy(1, n);
         checkOutput("rr grant length", 32'(n), 32'd4);
         if (g < 4) begin
            waitStart(waited);
            checkOutput("rr idle gap", 32'(waited), 32'd4);
         end
      end

      // Early release by owner 2 with a long slot
      applyStimulus(4'b0100, 3'd5);
      applyReset();
      waitStart(waited);
      checkOutput("release owner", 32'(bus.grant_id), 32'd2);
      repeat (3) tickCycle();
      applyStimulus(4'b1011, 3'd5);
      tickCycle();
      checkOutput("release grant", 32'(bus.grant), 32'h0);
      checkOutput("release grant_end", 32'(bus.grant_end), 32'd1);
      waitStart(waited);
      checkOutput("release next wait", 32'(waited), 32'd4);
      checkOutput("release next id", 32'(bus.grant_id), 32'd3);

      // slot_len=0 acts as 1; slot_len sampled only at arbitration
      applyStimulus(4'b0001, 3'd0);
      applyReset();
      waitStart(waited);
      measureBusy(1, n);
      checkOutput("len0 grant length", 32'(n), 32'd4);
      applyStimulus(4'b0001, 3'd3);
      waitStart(waited);
      tickCycle();
      applyStimulus(4'b0001, 3'd7);
      measureBusy(2, n);
      checkOutput("len3 grant length", 32'(n), 32'd12);

      // Release coinciding with the final tick
      applyStimulus(4'b0001, 3'd2);
      applyReset();
      waitStart(waited);
      repeat (7) tickCycle();
      checkOutput("simul tick present", 32'(bus.tick), 32'd1);
      applyStimulus(4'b0000, 3'd2);
      tickCycle();
      checkOutput("simul grant", 32'(bus.grant), 32'h0);
      checkOutput("simul grant_end", 32'(bus.grant_end), 32'd1);
      tickCycle();
      checkOutput("simul single end", 32'(bus.grant_end), 32'd0);
      checkOutput("simul idle", 32'(bus.busy), 32'd0);

      // Asynchronous reset in the middle of a grant
      applyStimulus(4'b0100, 3'd5);
      applyReset();
      waitStart(waited);
      tickCycle();
      checkOutput("pre-reset grant", 32'(bus.grant), 32'h4);
      #2 rst = 1'b1;
      #1;
      checkOutput("async reset grant", 32'(bus.grant), 32'h0);
      checkOutput("async reset busy", 32'(bus.busy), 32'd0);
      checkOutput("async reset grant_end", 32'(bus.grant_end), 32'd0);
      @(negedge clk);
      applyStimulus(4'b1111, 3'd1);
      bus.tick = 1'b0;
      @(negedge clk);
      rst       = 1'b0;
      tickPhase = 0;
      waitStart(waited);
      checkOutput("post-reset grant_id", 32'(bus.grant_id), 32'd0);

      // Random requests, lengths and occasional stray ticks
      applyReset();
      for (int i = 0; i < 3000; i++) begin
         tickCycle();
         if ($urandom_range(0, 7) == 0) bus.req = N_REQ'($urandom);
         bus.slot_len = LEN_W'($urandom);
         if ($urandom_range(0, 29) == 0) bus.tick = 1'b1;
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
